dest_pipe: RTL

Parametrised successor to the single-cycle write-destination mux. Selects the destination register from one of several instruction fields or a fixed link register, then carries {valid, address} through DEPTH pipeline stages to writeback. Exposes per-source hazard and forwarding-select outputs for the decode stage. Sits between decode and the register file write port.

---
 rtl/dest_pkg.sv | 29 ++
 rtl/dest_pipe_if.sv | 40 ++++
 rtl/dest_match.sv | 43 ++++
 rtl/dest_pipe.sv | 105 ++++++++++
 4 files changed

// File: rtl/dest_pkg.sv
// Shared types and helpers for the destination-register pipe.
//   dst_e        : RegDst encodings (rt, rd, link register, no write)
//   dest_entry_t : one pipeline stage {valid, addr}
//   fwd_w()      : width of a forwarding-select output for a given depth
// Build option: DEST_ZERO_REG_EN (see dest_pipe.sv) does not affect this file.
package dest_pkg;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_NONE = 2'b11
  } dst_e;

  // Stage address storage is sized for the widest register file we expect;
  // narrower instances zero-extend into it. REG_AW must not exceed this.
  localparam int unsigned REG_AW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] addr;
  } dest_entry_t;

  // Select must encode 0..depth-1 plus the "no match" value depth.
  function automatic int unsigned fwd_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dest_pipe_if.sv
// Decode-side bundle for dest_pipe.
//   master : decode stage (drives instruction/control/sources, reads results)
//   slave  : dest_pipe
//   instruction, reg_dst, reg_write, stall, flush, src1, src2 : decode -> pipe
//   write_register, wb_valid                                  : writeback port
//   hazard1/2, fwd1_sel/fwd2_sel                              : per-source match
interface dest_pipe_if
  import dest_pkg::*;
#(
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned REG_AW  = 2,
  parameter int unsigned DEPTH   = 3
);
  localparam int unsigned FwdW = fwd_w(DEPTH);

  logic [INSTR_W-1:0] instruction;
  logic [1:0]         reg_dst;
  logic               reg_write;
  logic               stall;
  logic               flush;
  logic [REG_AW-1:0]  src1;
  logic [REG_AW-1:0]  src2;
  logic [REG_AW-1:0]  write_register;
  logic               wb_valid;
  logic               hazard1;
  logic               hazard2;
  logic [FwdW-1:0]    fwd1_sel;
  logic [FwdW-1:0]    fwd2_sel;

  modport master (
    output instruction, reg_dst, reg_write, stall, flush, src1, src2,
    input  write_register, wb_valid, hazard1, hazard2, fwd1_sel, fwd2_sel
  );

  modport slave (
    input  instruction, reg_dst, reg_write, stall, flush, src1, src2,
    output write_register, wb_valid, hazard1, hazard2, fwd1_sel, fwd2_sel
  );

endinterface

// File: rtl/dest_match.sv
// Per-source comparator and priority encoder over the in-flight stages.
//   valid_i  : per-stage valid bits
//   addr_i   : per-stage destination addresses (zero-extended)
//   src_i    : source address from decode
//   hazard_o : some valid stage writes src_i
//   sel_o    : youngest (lowest-index) matching stage, DEPTH when none
// Build option: DEST_ZERO_REG_EN masks matches on register 0.
module dest_match
  import dest_pkg::*;
#(
  parameter int unsigned REG_AW = 2,
  parameter int unsigned DEPTH  = 3,
  localparam int unsigned FwdW  = fwd_w(DEPTH)
) (
  input  logic [DEPTH-1:0]                 valid_i,
  input  logic [DEPTH-1:0][REG_AW_MAX-1:0] addr_i,
  input  logic [REG_AW-1:0]                src_i,
  output logic                             hazard_o,
  output logic [FwdW-1:0]                  sel_o
);

  logic [REG_AW_MAX-1:0] src_ext;
  assign src_ext = REG_AW_MAX'(src_i);

  always_comb begin
    hazard_o = 1'b0;
    sel_o    = FwdW'(DEPTH);
    // Walk oldest to youngest so the lowest matching index is the one left.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_i[i] && (addr_i[i] == src_ext)) begin
        hazard_o = 1'b1;
        sel_o    = FwdW'(i);
      end
    end
`ifdef DEST_ZERO_REG_EN
    if (src_i == '0) begin
      hazard_o = 1'b0;
      sel_o    = FwdW'(DEPTH);
    end
`endif
  end

endmodule

// File: rtl/dest_pipe.sv
// Write-destination select plus DEPTH-stage {valid, addr} pipe to writeback,
// with per-source hazard/forward-select outputs for decode.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous reset, active low; discards all in-flight entries
//   bus    : dest_pipe_if slave (see interface header for signal list)
// Build option: DEST_ZERO_REG_EN hardwires register 0 (never written, never
// reported as a hazard). Undefined: register 0 is an ordinary register.
module dest_pipe
  import dest_pkg::*;
#(
  parameter int unsigned INSTR_W  = 8,
  parameter int unsigned REG_AW   = 2,
  parameter int unsigned RT_LSB   = 2,
  parameter int unsigned RD_LSB   = 0,
  parameter int unsigned LINK_REG = (1 << REG_AW) - 1,
  parameter int unsigned DEPTH    = 3
) (
  input logic        clk_i,
  input logic        rst_ni,
  dest_pipe_if.slave bus
);

  dest_entry_t stage_q [DEPTH];
  dest_entry_t stage_d [DEPTH];
  dest_entry_t incoming;
  logic [REG_AW-1:0] inc_addr;

  // Only the rt/rd fields are consumed; the rest of the word is ignored.
  logic unused_instr;
  assign unused_instr = ^bus.instruction;

  always_comb begin
    inc_addr = '0;
    unique case (dst_e'(bus.reg_dst))
      DST_RT:   inc_addr = bus.instruction[RT_LSB +: REG_AW];
      DST_RD:   inc_addr = bus.instruction[RD_LSB +: REG_AW];
      DST_LINK: inc_addr = REG_AW'(LINK_REG);
      DST_NONE: inc_addr = '0;
      default:  inc_addr = '0;
    endcase
    incoming.addr  = REG_AW_MAX'(inc_addr);
    incoming.valid = bus.reg_write && (dst_e'(bus.reg_dst) != DST_NONE);
`ifdef DEST_ZERO_REG_EN
    if (inc_addr == '0) incoming.valid = 1'b0;
`endif
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
    if (bus.flush) begin
      // Killing stage 0 means stage 1 receives nothing; older stages still advance.
      stage_d[0] = '0;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = (i == 1) ? '0 : stage_q[i-1];
      end
    end else if (!bus.stall) begin
      stage_d[0] = incoming;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign bus.write_register = stage_q[DEPTH-1].addr[REG_AW-1:0];
  assign bus.wb_valid       = stage_q[DEPTH-1].valid;

  logic [DEPTH-1:0]                 stage_valid;
  logic [DEPTH-1:0][REG_AW_MAX-1:0] stage_addr;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_valid[i] = stage_q[i].valid;
      stage_addr[i]  = stage_q[i].addr;
    end
  end

  dest_match #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_match1 (
    .valid_i  (stage_valid),
    .addr_i   (stage_addr),
    .src_i    (bus.src1),
    .hazard_o (bus.hazard1),
    .sel_o    (bus.fwd1_sel)
  );

  dest_match #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_match2 (
    .valid_i  (stage_valid),
    .addr_i   (stage_addr),
    .src_i    (bus.src2),
    .hazard_o (bus.hazard2),
    .sel_o    (bus.fwd2_sel)
  );

endmodule
